// File: rtl/washer_pkg.sv
// Shared definitions for the washer controllers: FSM state encodings,
// default tick counts and small elaboration-time helpers.
package washer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SETTLE = 2'd2
  } arb_state_e;

  // Washer timing defaults, all in units of the shared tick strobe
  localparam int WASH_TICKS_DEF     = 40;
  localparam int SPIN_TICKS_DEF     = 20;
  localparam int DRAIN_TICKS_DEF    = 10;
  localparam int FILL_GAP_TICKS_DEF = 2;
  localparam int FILL_MAX_TICKS_DEF = 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fill_valve_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Shared by the valve arbiter and other single-resource arbiters.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [N-1:0] sel,
  output logic [W-1:0] idx
);

  function automatic logic [W-1:0] slot(input logic [W-1:0] p, input int i);
    return W'((int'(p) + i) % N);
  endfunction

  always_comb begin
    valid = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[slot(ptr, i)]) begin
        valid             = 1'b1;
        sel[slot(ptr, i)] = 1'b1;
        idx               = slot(ptr, i);
      end
    end
  end

endmodule

// File: rtl/fill_valve_arbiter.sv
// Round-robin arbiter for the shared water-inlet valve, with a settle gap between grants.
// Build macro FILL_TIMEOUT_EN: force-release grants held MAX_FILL_TICKS and flag them.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | valve closed, arbitrating among unmasked requesters
// ST_GRANT  | one machine holds the valve, counting ticks of fill
// ST_SETTLE | valve closed, waiting GAP_TICKS for line pressure
module fill_valve_arbiter
  import washer_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int GAP_TICKS      = FILL_GAP_TICKS_DEF,
  parameter  int MAX_FILL_TICKS = FILL_MAX_TICKS_DEF,
  parameter  int CNT_W          = 4,
  localparam int ID_W           = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               valve_open,
  output logic               busy,
  output logic [NUM_REQ-1:0] timeout_err
);

  if (CNT_W < clog2(GAP_TICKS + 1) || CNT_W < clog2(MAX_FILL_TICKS + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow for GAP_TICKS / MAX_FILL_TICKS");
  end

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ID_W-1:0]    ptr_q, ptr_d, ptr_nxt;
  logic [NUM_REQ-1:0] gnt_d, err_d, req_arb;
  logic [ID_W-1:0]    gnt_id_d;
  logic               release_now;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_sel;
  logic [ID_W-1:0]    pick_idx;

  // Timed-out machines stay out of arbitration until they drop req
  assign req_arb = req & ~timeout_err;

  rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req   (req_arb),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .sel   (pick_sel),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt         <= '0;
      gnt_id      <= '0;
      valve_open  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt         <= gnt_d;
      gnt_id      <= gnt_id_d;
      valve_open  <= |gnt_d;
      busy        <= (state_d != ST_IDLE);
      timeout_err <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt;
    gnt_id_d    = gnt_id;
    release_now = 1'b0;
    cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    ptr_nxt     = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef FILL_TIMEOUT_EN
    err_d       = timeout_err & (req | gnt);
`else
    err_d       = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_GRANT;
          cnt_d    = '0;
          gnt_d    = pick_sel;
          gnt_id_d = pick_idx;
        end
      end
      ST_GRANT: begin
        // A release in the same cycle as a tick swallows that tick
        release_now = !req[gnt_id];
        if (!release_now && tick) begin
          cnt_d = cnt_inc;
`ifdef FILL_TIMEOUT_EN
          if (cnt_inc == CNT_W'(MAX_FILL_TICKS)) begin
            release_now   = 1'b1;
            err_d[gnt_id] = 1'b1;
          end
`endif
        end
        if (release_now) begin
          state_d  = ST_SETTLE;
          cnt_d    = '0;
          gnt_d    = '0;
          gnt_id_d = '0;
          ptr_d    = ptr_nxt;
        end
      end
      ST_SETTLE: begin
        if (tick) begin
          if (cnt_inc == CNT_W'(GAP_TICKS)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        gnt_d    = '0;
        gnt_id_d = '0;
        err_d    = '0;
      end
    endcase
  end

endmodule

// File: doc/fill_valve_arbiter.md
Name: fill_valve_arbiter

Overview:
- Shares the single building water-inlet valve between NUM_REQ washing-machine controllers.
- Each controller raises its req bit during its filling phase. The arbiter grants one machine at a time, round-robin, and drives the valve open only while a grant is held.
- Enforces a settle gap between consecutive grants for line pressure.
- Sits between the per-machine wash controllers and the valve driver.
- Time base is the same slow `tick` strobe the wash controllers use.

Parameters:
- NUM_REQ, 4, number of washing machines sharing the valve (2..8).
- GAP_TICKS, 2, ticks the valve stays closed between two grants (>=1).
- MAX_FILL_TICKS, 6, maximum ticks one grant may be held (used only with FILL_TIMEOUT_EN).
- CNT_W, 4, width of the tick counter; must hold max(GAP_TICKS, MAX_FILL_TICKS).

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle time-base strobe.
- req  input  NUM_REQ  level request per machine; held high for the whole fill.
- gnt  output  NUM_REQ  one-hot grant, or all zero.
- gnt_id  output  $clog2(NUM_REQ)  index of granted machine; 0 when no grant.
- valve_open  output  1  valve drive; high exactly when gnt is non-zero.
- busy  output  1  high in GRANT or SETTLE.
- timeout_err  output  NUM_REQ  sticky per-machine fill-timeout flag.

Behaviour:
- Reset is synchronous (sampled on posedge clk when rst=1). After reset:
  - gnt=0, gnt_id=0, valve_open=0, busy=0, timeout_err=0.
  - state=IDLE, counter=0.
  - Round-robin pointer = 0, so index 0 has highest priority first.
- All outputs are registered.

States and transitions:
- IDLE:
  - If any req bit is high, select the first requester at or after the pointer, wrapping from NUM_REQ-1 to 0.
  - Next cycle: gnt/gnt_id/valve_open asserted, state=GRANT, counter=0.
  - Latency from req rising to gnt is 1 cycle. tick is not needed.
- GRANT:
  - Grant is held while req[gnt_id]=1.
  - The counter increments on each tick, saturating at all-ones.
  - When req[gnt_id] falls:
    - gnt and valve_open drop on the next cycle.
    - Pointer becomes gnt_id+1 (mod NUM_REQ).
    - State=SETTLE, counter=0.
  - Requests from other machines are ignored during GRANT. There is no preemption.
- SETTLE:
  - The valve stays closed. The counter increments on each tick.
  - When the counter reaches GAP_TICKS, go to IDLE with counter=0.
  - The arbitration decision is made in IDLE, not in SETTLE.
- The default (illegal) state encoding recovers to IDLE with all outputs cleared.

Boundary conditions:
- Simultaneous requests: strict round-robin from the pointer. A requester is never starved for more than NUM_REQ-1 grants.
- req drops in the same cycle as a tick: the release takes priority and the tick is discarded.
- Requester re-raises req during SETTLE: it competes normally in IDLE. The pointer has already passed it, so others go first.
- req pulse shorter than one cycle between samples is not seen. A req seen in IDLE yields a grant of at least 1 cycle.
- rst mid-GRANT: the valve closes on that edge and the pointer returns to 0.
- timeout_err[i] clears only when req[i] is low and the machine is not granted, or on rst.

Optional Feature:
- Macro: FILL_TIMEOUT_EN.
- Defined:
  - In GRANT, when the counter reaches MAX_FILL_TICKS on a tick, the grant is force-released. The next cycle matches a normal release (valve closed, SETTLE, pointer advanced).
  - timeout_err[gnt_id] is set in that same cycle.
  - While timeout_err[i]=1, req[i] is masked from arbitration until req[i] is seen low.
- Not defined:
  - No time limit on a grant; the grant is held until req drops.
  - timeout_err is tied to 0.
  - MAX_FILL_TICKS is unused.

Decomposition:
- Shared package washer_pkg holds:
  - The state encoding for IDLE/GRANT/SETTLE as a 2-bit enum.
  - Default tick-count constants alongside the existing washer timing constants.
  - A clog2 helper function.
- One combinational sub-module, rr_pick: inputs are the request vector and pointer; outputs are a valid flag, a one-hot select and an index. It is reusable for other shared-resource arbiters such as the detergent pump.

Test Plan:
- Reset then req=4'b0001 -> 1 cycle later gnt=0001, gnt_id=0, valve_open=1, busy=1. Drop req -> next cycle gnt=0, valve_open=0. After 2 ticks -> busy=0.
- req=4'b1010 held from IDLE with pointer 0 -> gnt=0010 first. Release req[1] -> after the 2-tick gap, gnt=1000.
- Round-robin: all four req held, each released after 1 tick of grant -> grant order 0,1,2,3,0. No machine is granted twice before every other holder is served.
- req[2] drops in the same cycle as a tick -> grant released and counter=0 in SETTLE. No extra count is observed.
- rst=1 asserted mid-GRANT -> next edge gnt=0, valve_open=0, state IDLE. With req=1111 after rst=0 -> gnt=0001.
- FILL_TIMEOUT_EN defined, req[3] held for 10 ticks -> force release at tick 6 and timeout_err=1000. req[3] is not regranted until it goes low. After req[3] goes low -> timeout_err=0000.
